cache_core_req_bank_sel: RTL and testbench
==========================================

// Module: cache_core_req_bank_sel
// PURPOSE
//  Combinational crossbar front-end of the cache/shared-memory request path.
//  - Maps NUM_REQS per-lane core requests onto NUM_BANKS bank slots; one request per bank per cycle.
//  - Resolves bank conflicts by fixed priority and returns per-lane ready.
//  - Keeps a bank-conflict stall counter.
//  - Sits between the core request ports and the bank request queue / data RAMs.
// PARAMETERS
//  CACHE_ID          0     instance id (debug only)
//  CACHE_LINE_SIZE   64    line size in bytes (power of 2, >= WORD_SIZE)
//  NUM_BANKS         4     number of banks (power of 2, <= NUM_REQS)
//  NUM_PORTS         1     ports per bank; only 1 supported (static assert)
//  WORD_SIZE         4     word size in bytes
//  NUM_REQS          4     core request lanes
//  CORE_TAG_WIDTH    1     request tag width
//  BANK_ADDR_OFFSET  0     bank-select field offset above word-select bits
//  SHARED_BANK_READY 0     1: single global bank ready; 0: per-bank ready
// PORTS  (shared constants: WAW=32-log2(WORD_SIZE), WSB=log2(CACHE_LINE_SIZE/WORD_SIZE),
//         BSB=log2(NUM_BANKS), LAW=WAW-WSB-BSB, RB=max(1,log2(NUM_REQS)), RW=SHARED_BANK_READY?1:NUM_BANKS)
//  clk                      in   1                  clock
//  reset                    in   1                  asynchronous, active-low
//  core_req_valid           in   NUM_REQS           lane request valid
//  core_req_rw              in   NUM_REQS           1 = write
//  core_req_addr            in   NUM_REQS*WAW       word address
//  core_req_byteen          in   NUM_REQS*WORD_SIZE byte enables
//  core_req_data            in   NUM_REQS*8*WORD_SIZE write data
//  core_req_tag             in   NUM_REQS*CORE_TAG_WIDTH tag
//  core_req_ready           out  NUM_REQS           lane accepted this cycle
//  per_bank_core_req_valid  out  NUM_BANKS          bank slot valid
//  per_bank_core_req_tid    out  NUM_BANKS*RB       winning lane index
//  per_bank_core_req_rw     out  NUM_BANKS          forwarded rw
//  per_bank_core_req_addr   out  NUM_BANKS*LAW      line address with bank bits removed
//  per_bank_core_req_wsel   out  NUM_BANKS*max(1,WSB) word select within line
//  per_bank_core_req_byteen out  NUM_BANKS*WORD_SIZE forwarded byteen
//  per_bank_core_req_data   out  NUM_BANKS*8*WORD_SIZE forwarded data
//  per_bank_core_req_tag    out  NUM_BANKS*CORE_TAG_WIDTH forwarded tag
//  per_bank_core_req_ready  in   RW                 bank(s) can accept
//  bank_stalls              out  44                 cumulative conflict-stall count
// BEHAVIOUR
//  - Address split: wsel=addr[WSB-1:0] (0 if WSB=0);
//    bank=addr[WSB+BANK_ADDR_OFFSET +: BSB] (0 if BSB=0);
//    line addr = addr with the BSB bank bits removed, remaining bits concatenated in order.
//  - Per bank b: winner = lowest-index valid lane with bank==b.
//    per_bank valid=1, tid=winner, other fields copied from winner.
//  - Bank with no requester: valid=0, all other bank outputs driven 0.
//  - Bank ready for lane i: SHARED_BANK_READY=1 -> per_bank_core_req_ready[0];
//    SHARED_BANK_READY=0 -> per_bank_core_req_ready[bank(i)].
//  - core_req_ready[i] = core_req_valid[i] & winner(bank(i))==i & bank ready.
//    Invalid lanes read 0; losing lanes read 0 and must hold their request.
//  - Bank-slot outputs depend only on valid/addr, never on ready (no ready->valid path).
//  - All datapath logic combinational, zero latency; the only state is bank_stalls.
//  - bank_stalls:
//    - Each cycle adds popcount of valid lanes that lost arbitration (bank-not-ready stalls excluded).
//    - Wraps modulo 2^44.
//    - Reset (async, reset==0) forces 0; held at 0 while reset asserted.
//  - Single bank (BSB=0): all valid lanes conflict; only lowest valid lane is accepted.
//  - NUM_PORTS!=1 or NUM_BANKS>NUM_REQS: elaboration error.
// STRUCTURE
//  - Shared package: WAW/WSB/BSB/LAW/RB width constants and address-split helper functions.
//  - Natural sub-module: cache_bank_priority_arb (per-bank fixed-priority one-hot grant over NUM_REQS).
//  - Rest is generate loops plus the counter.
// TESTING  (NUM_BANKS=4, NUM_REQS=4, WORD_SIZE=4, CACHE_LINE_SIZE=4, offset 0, SHARED_BANK_READY=1)
//  1. Valid=4'hF, addr={3,2,1,0}, ready=1.
//     -> all banks valid, tid[b]=b, core_req_ready=4'hF, bank_stalls stays 0.
//  2. Lane0 addr 0x4 and lane1 addr 0x8 (both bank 0).
//     -> bank0 tid=0, line 0x1; core_req_ready=4'b0001; bank_stalls +1 per cycle.
//  3. Lane2 addr 0x13, rw=1, byteen=4'b0011.
//     -> bank3 valid, line 0x4, tid=2, rw/byteen/data/tag forwarded; other banks valid=0.
//  4. Case 1 with per_bank_core_req_ready=0.
//     -> core_req_ready=0, bank outputs unchanged, bank_stalls unchanged.
//  5. Reset low mid-run after bank_stalls=5.
//     -> bank_stalls=0 immediately; counting resumes after release.
//  6. SHARED_BANK_READY=0, ready=4'b1011, Case 1 stimulus.
//     -> core_req_ready=4'b1011.

Source files
------------

// File: rtl/cache_core_req_bank_sel_pkg.sv
// rtl/cache_core_req_bank_sel_pkg.sv - width constants and address-split helpers for the bank selector
package cache_core_req_bank_sel_pkg;

   localparam int ADDR_BITS    = 32;
   localparam int STALL_BITS   = 44;

   function automatic int max1(input int v);
      return (v > 1) ? v : 1;
   endfunction

   function automatic int calc_waw(input int word_size);
      return ADDR_BITS - $clog2(word_size);
   endfunction

   function automatic int calc_wsb(input int line_size, input int word_size);
      return $clog2(line_size / word_size);
   endfunction

   function automatic int calc_bsb(input int num_banks);
      return $clog2(num_banks);
   endfunction

   function automatic int calc_law(input int word_size, input int line_size, input int num_banks);
      return calc_waw(word_size) - calc_wsb(line_size, word_size) - calc_bsb(num_banks);
   endfunction

   function automatic int calc_rb(input int num_reqs);
      return max1($clog2(num_reqs));
   endfunction

   function automatic logic [31:0] field_mask(input int bits);
      return (bits >= 32) ? '1 : ((32'd1 << bits) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_wsel(input logic [31:0] addr, input int wsb);
      return addr & field_mask(wsb);
   endfunction

   function automatic logic [31:0] addr_bank(input logic [31:0] addr, input int wsb,
                                             input int bsb, input int off);
      return (addr >> (wsb + off)) & field_mask(bsb);
   endfunction

   // Bank bits are squeezed out; the bits between word-select and bank field stay in place.
   function automatic logic [31:0] addr_line(input logic [31:0] addr, input int wsb,
                                             input int bsb, input int off);
      logic [31:0] low;
      logic [31:0] high;
      low  = (addr >> wsb) & field_mask(off);
      high = addr >> (wsb + off + bsb);
      return (high << off) | low;
   endfunction

endpackage

// File: rtl/cache_bank_priority_arb.sv
// rtl/cache_bank_priority_arb.sv - fixed-priority one-hot grant, lowest index wins
module cache_bank_priority_arb #(
   parameter int NUM_REQS = 4
) (
   input  logic [NUM_REQS-1:0] i_req,
   output logic [NUM_REQS-1:0] o_grant,
   output logic                o_valid
);

   assign o_grant = i_req & (~i_req + NUM_REQS'(1));
   assign o_valid = |i_req;

endmodule

// File: rtl/cache_core_req_bank_sel.sv
// rtl/cache_core_req_bank_sel.sv - core-lane to bank-slot crossbar with conflict arbitration and stall counter
module cache_core_req_bank_sel
   import cache_core_req_bank_sel_pkg::*;
#(
   parameter int CACHE_ID          = 0,
   parameter int CACHE_LINE_SIZE   = 64,
   parameter int NUM_BANKS         = 4,
   parameter int NUM_PORTS         = 1,
   parameter int WORD_SIZE         = 4,
   parameter int NUM_REQS          = 4,
   parameter int CORE_TAG_WIDTH    = 1,
   parameter int BANK_ADDR_OFFSET  = 0,
   parameter int SHARED_BANK_READY = 0,
   localparam int WAW  = calc_waw(WORD_SIZE),
   localparam int WSB  = calc_wsb(CACHE_LINE_SIZE, WORD_SIZE),
   localparam int BSB  = calc_bsb(NUM_BANKS),
   localparam int LAW  = calc_law(WORD_SIZE, CACHE_LINE_SIZE, NUM_BANKS),
   localparam int RB   = calc_rb(NUM_REQS),
   localparam int RW   = (SHARED_BANK_READY != 0) ? 1 : NUM_BANKS,
   localparam int WSBW = max1(WSB)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_REQS-1:0]                   core_req_valid,
   input  logic [NUM_REQS-1:0]                   core_req_rw,
   input  logic [NUM_REQS*WAW-1:0]               core_req_addr,
   input  logic [NUM_REQS*WORD_SIZE-1:0]         core_req_byteen,
   input  logic [NUM_REQS*8*WORD_SIZE-1:0]       core_req_data,
   input  logic [NUM_REQS*CORE_TAG_WIDTH-1:0]    core_req_tag,
   output logic [NUM_REQS-1:0]                   core_req_ready,
   output logic [NUM_BANKS-1:0]                  per_bank_core_req_valid,
   output logic [NUM_BANKS*RB-1:0]               per_bank_core_req_tid,
   output logic [NUM_BANKS-1:0]                  per_bank_core_req_rw,
   output logic [NUM_BANKS*LAW-1:0]              per_bank_core_req_addr,
   output logic [NUM_BANKS*WSBW-1:0]             per_bank_core_req_wsel,
   output logic [NUM_BANKS*WORD_SIZE-1:0]        per_bank_core_req_byteen,
   output logic [NUM_BANKS*8*WORD_SIZE-1:0]      per_bank_core_req_data,
   output logic [NUM_BANKS*CORE_TAG_WIDTH-1:0]   per_bank_core_req_tag,
   input  logic [RW-1:0]                         per_bank_core_req_ready,
   output logic [STALL_BITS-1:0]                 bank_stalls
);

   localparam int BSBW = max1(BSB);
   localparam int LCW  = $clog2(NUM_REQS + 1);

   if (NUM_PORTS != 1) begin : g_err_ports
      $error("cache_core_req_bank_sel: only NUM_PORTS=1 is supported");
   end
   if (NUM_BANKS > NUM_REQS) begin : g_err_banks
      $error("cache_core_req_bank_sel: NUM_BANKS must not exceed NUM_REQS");
   end
   if (CACHE_ID < 0) begin : g_err_id
      $error("cache_core_req_bank_sel: CACHE_ID must be non-negative");
   end

   logic [31:0]           w_addr32 [NUM_REQS];
   logic [31:0]           w_wsel32 [NUM_REQS];
   logic [31:0]           w_bank32 [NUM_REQS];
   logic [31:0]           w_line32 [NUM_REQS];
   logic [NUM_REQS-1:0]   w_lane_rdy;
   logic [NUM_REQS-1:0]   w_lane_win;
   logic [NUM_REQS-1:0]   w_lost;
   logic [NUM_REQS-1:0]   w_bank_req [NUM_BANKS];
   logic [NUM_REQS-1:0]   w_grant    [NUM_BANKS];
   logic [NUM_BANKS-1:0]  w_bank_valid;
   logic [LCW-1:0]        w_lost_cnt;
   logic                  w_unused;
   logic [STALL_BITS-1:0] r_bank_stalls;

   for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
      assign w_addr32[i] = 32'(core_req_addr[i*WAW +: WAW]);
      assign w_wsel32[i] = addr_wsel(w_addr32[i], WSB);
      assign w_bank32[i] = addr_bank(w_addr32[i], WSB, BSB, BANK_ADDR_OFFSET);
      assign w_line32[i] = addr_line(w_addr32[i], WSB, BSB, BANK_ADDR_OFFSET);
      if (SHARED_BANK_READY != 0 || NUM_BANKS == 1) begin : g_rdy_shared
         assign w_lane_rdy[i] = per_bank_core_req_ready[0];
      end else begin : g_rdy_bank
         assign w_lane_rdy[i] = per_bank_core_req_ready[w_bank32[i][BSBW-1:0]];
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
         assign w_bank_req[b][i] = core_req_valid[i] & (w_bank32[i][BSBW-1:0] == BSBW'(b));
      end
      cache_bank_priority_arb #(
         .NUM_REQS (NUM_REQS)
      ) u_arb (
         .i_req   (w_bank_req[b]),
         .o_grant (w_grant[b]),
         .o_valid (w_bank_valid[b])
      );
   end

   // Grants are one-hot, so at most one lane lands in each slot; empty slots stay all-zero.
   always_comb begin
      per_bank_core_req_tid    = '0;
      per_bank_core_req_rw     = '0;
      per_bank_core_req_addr   = '0;
      per_bank_core_req_wsel   = '0;
      per_bank_core_req_byteen = '0;
      per_bank_core_req_data   = '0;
      per_bank_core_req_tag    = '0;
      w_lane_win               = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            if (w_grant[b][i]) begin
               w_lane_win[i]                                           = 1'b1;
               per_bank_core_req_tid[b*RB +: RB]                       = RB'(i);
               per_bank_core_req_rw[b]                                 = core_req_rw[i];
               per_bank_core_req_addr[b*LAW +: LAW]                    = w_line32[i][LAW-1:0];
               per_bank_core_req_wsel[b*WSBW +: WSBW]                  = w_wsel32[i][WSBW-1:0];
               per_bank_core_req_byteen[b*WORD_SIZE +: WORD_SIZE]      = core_req_byteen[i*WORD_SIZE +: WORD_SIZE];
               per_bank_core_req_data[b*8*WORD_SIZE +: 8*WORD_SIZE]    = core_req_data[i*8*WORD_SIZE +: 8*WORD_SIZE];
               per_bank_core_req_tag[b*CORE_TAG_WIDTH +: CORE_TAG_WIDTH] = core_req_tag[i*CORE_TAG_WIDTH +: CORE_TAG_WIDTH];
            end
         end
      end
   end

   assign per_bank_core_req_valid = w_bank_valid;
   assign core_req_ready          = core_req_valid & w_lane_win & w_lane_rdy;
   assign w_lost                  = core_req_valid & ~w_lane_win;

   always_comb begin
      w_lost_cnt = '0;
      w_unused   = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         w_lost_cnt = w_lost_cnt + LCW'(w_lost[i]);
         w_unused   = w_unused ^ (^w_addr32[i]) ^ (^w_wsel32[i]) ^ (^w_bank32[i]) ^ (^w_line32[i]);
      end
   end

   // Only arbitration losers count; a winner blocked by bank ready is not a conflict.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bank_stalls <= '0;
      end else begin
         r_bank_stalls <= r_bank_stalls + STALL_BITS'(w_lost_cnt);
      end
   end

   assign bank_stalls = r_bank_stalls;

endmodule

// File: tb/tb_cache_core_req_bank_sel.sv
// tb/tb_cache_core_req_bank_sel.sv - self-checking bench for cache_core_req_bank_sel
module tb_cache_core_req_bank_sel;

   typedef struct {
      logic [3:0]       valid;
      logic [3:0][29:0] a;
      logic [3:0]       rw;
      logic [15:0]      be;
      logic             rdy0;
      logic [3:0]       rdy1;
      logic [3:0]       exp_r0;
      logic [3:0]       exp_r1;
      logic [3:0]       exp_bv;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0]   valid, rw, tag, rdy1;
   logic [119:0] addr;
   logic [15:0]  byteen;
   logic [127:0] data;
   logic         rdy0;

   logic [3:0]   d0_ready, d0_bv, d0_rw, d0_wsel, d0_tag;
   logic [7:0]   d0_tid;
   logic [111:0] d0_addr;
   logic [15:0]  d0_be;
   logic [127:0] d0_data;
   logic [43:0]  d0_stalls;
   logic [3:0]   d1_ready, d1_bv, d1_rw, d1_wsel, d1_tag;
   logic [7:0]   d1_tid;
   logic [111:0] d1_addr;
   logic [15:0]  d1_be;
   logic [127:0] d1_data;
   logic [43:0]  d1_stalls;

   cache_core_req_bank_sel #(
      .CACHE_ID(0), .CACHE_LINE_SIZE(4), .NUM_BANKS(4), .NUM_PORTS(1), .WORD_SIZE(4),
      .NUM_REQS(4), .CORE_TAG_WIDTH(1), .BANK_ADDR_OFFSET(0), .SHARED_BANK_READY(1)
   ) u_dut0 (
      .clk(clk), .reset(rst_n),
      .core_req_valid(valid), .core_req_rw(rw), .core_req_addr(addr),
      .core_req_byteen(byteen), .core_req_data(data), .core_req_tag(tag),
      .core_req_ready(d0_ready),
      .per_bank_core_req_valid(d0_bv), .per_bank_core_req_tid(d0_tid),
      .per_bank_core_req_rw(d0_rw), .per_bank_core_req_addr(d0_addr),
      .per_bank_core_req_wsel(d0_wsel), .per_bank_core_req_byteen(d0_be),
      .per_bank_core_req_data(d0_data), .per_bank_core_req_tag(d0_tag),
      .per_bank_core_req_ready(rdy0), .bank_stalls(d0_stalls)
   );

   cache_core_req_bank_sel #(
      .CACHE_ID(1), .CACHE_LINE_SIZE(4), .NUM_BANKS(4), .NUM_PORTS(1), .WORD_SIZE(4),
      .NUM_REQS(4), .CORE_TAG_WIDTH(1), .BANK_ADDR_OFFSET(0), .SHARED_BANK_READY(0)
   ) u_dut1 (
      .clk(clk), .reset(rst_n),
      .core_req_valid(valid), .core_req_rw(rw), .core_req_addr(addr),
      .core_req_byteen(byteen), .core_req_data(data), .core_req_tag(tag),
      .core_req_ready(d1_ready),
      .per_bank_core_req_valid(d1_bv), .per_bank_core_req_tid(d1_tid),
      .per_bank_core_req_rw(d1_rw), .per_bank_core_req_addr(d1_addr),
      .per_bank_core_req_wsel(d1_wsel), .per_bank_core_req_byteen(d1_be),
      .per_bank_core_req_data(d1_data), .per_bank_core_req_tag(d1_tag),
      .per_bank_core_req_ready(rdy1), .bank_stalls(d1_stalls)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [43:0] exp_stalls;

   logic [29:0]  l_addr [4];
   logic [31:0]  l_data [4];
   logic [3:0]   l_be   [4];

   logic [3:0]   e_r0, e_r1, e_bv, e_rw, e_tag;
   logic [7:0]   e_tid;
   logic [111:0] e_addr;
   logic [15:0]  e_be;
   logic [127:0] e_data;
   int           m_lost;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Bank = word address mod 4, line = word address / 4 for this configuration.
   task automatic model();
      int win [4];
      int bk;
      int nv;
      int nw;
      for (int b = 0; b < 4; b++) win[b] = -1;
      nv = 0;
      for (int i = 0; i < 4; i++) begin
         if (valid[i]) begin
            nv++;
            bk = int'(l_addr[i] % 4);
            if (win[bk] < 0) win[bk] = i;
         end
      end
      {e_bv, e_rw, e_tag, e_tid, e_addr, e_be, e_data} = '0;
      nw = 0;
      for (int b = 0; b < 4; b++) begin
         if (win[b] >= 0) begin
            nw++;
            e_bv[b]              = 1'b1;
            e_tid[b*2 +: 2]      = 2'(win[b]);
            e_rw[b]              = rw[win[b]];
            e_tag[b]             = tag[win[b]];
            e_addr[b*28 +: 28]   = 28'(l_addr[win[b]] / 4);
            e_be[b*4 +: 4]       = l_be[win[b]];
            e_data[b*32 +: 32]   = l_data[win[b]];
         end
      end
      for (int i = 0; i < 4; i++) begin
         bk = int'(l_addr[i] % 4);
         e_r0[i] = valid[i] && win[bk] == i && rdy0;
         e_r1[i] = valid[i] && win[bk] == i && rdy1[bk];
      end
      m_lost = nv - nw;
   endtask

   task automatic pack();
      for (int i = 0; i < 4; i++) begin
         addr[i*30 +: 30]  = l_addr[i];
         data[i*32 +: 32]  = l_data[i];
         byteen[i*4 +: 4]  = l_be[i];
      end
   endtask

   task automatic run_cycle(input string nm, input bit has_tbl, input vec_t v);
      pack();
      model();
      @(negedge clk);
      chk({nm, " ready0"}, d0_ready, e_r0);
      chk({nm, " ready1"}, d1_ready, e_r1);
      chk({nm, " bvalid"}, d0_bv, e_bv);
      chk({nm, " bvalid1"}, d1_bv, e_bv);
      chk({nm, " tid"}, d0_tid, e_tid);
      chk({nm, " rw"}, d0_rw, e_rw);
      chk({nm, " line"}, d0_addr, e_addr);
      chk({nm, " wsel"}, d0_wsel, 4'h0);
      chk({nm, " byteen"}, d0_be, e_be);
      chk({nm, " data"}, d0_data, e_data);
      chk({nm, " tag"}, d0_tag, e_tag);
      chk({nm, " stalls0"}, d0_stalls, exp_stalls);
      chk({nm, " stalls1"}, d1_stalls, exp_stalls);
      if (has_tbl) begin
         chk({nm, " tbl_ready0"}, d0_ready, v.exp_r0);
         chk({nm, " tbl_ready1"}, d1_ready, v.exp_r1);
         chk({nm, " tbl_bvalid"}, d0_bv, v.exp_bv);
      end
      @(posedge clk);
      if (rst_n) exp_stalls = exp_stalls + 44'(m_lost);
      #1;
   endtask

   task automatic load(input vec_t v);
      valid = v.valid;
      rw    = v.rw;
      rdy0  = v.rdy0;
      rdy1  = v.rdy1;
      tag   = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
         l_addr[i] = v.a[i];
         l_be[i]   = v.be[i*4 +: 4];
         l_data[i] = $urandom;
      end
   endtask

   function automatic vec_t mk(input logic [3:0] vl, input logic [3:0][29:0] a,
                               input logic [3:0] r, input logic [15:0] be,
                               input logic rd0, input logic [3:0] rd1,
                               input logic [3:0] x0, input logic [3:0] x1, input logic [3:0] xb);
      vec_t v;
      v.valid = vl; v.a = a; v.rw = r; v.be = be; v.rdy0 = rd0; v.rdy1 = rd1;
      v.exp_r0 = x0; v.exp_r1 = x1; v.exp_bv = xb;
      return v;
   endfunction

   vec_t tbl [9];
   vec_t none;

   initial begin
      #200000;
      $display("FAIL timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = mk(4'hF, {30'd3, 30'd2, 30'd1, 30'd0}, 4'h0, 16'hFFFF, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF);
      tbl[1] = mk(4'h3, {30'd0, 30'd0, 30'h8, 30'h4}, 4'h0, 16'hFFFF, 1'b1, 4'hF, 4'h1, 4'h1, 4'h1);
      tbl[2] = mk(4'h4, {30'd0, 30'h13, 30'd0, 30'd0}, 4'h4, 16'h0300, 1'b1, 4'hF, 4'h4, 4'h4, 4'h8);
      tbl[3] = mk(4'hF, {30'd3, 30'd2, 30'd1, 30'd0}, 4'h0, 16'hFFFF, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
      tbl[4] = mk(4'hF, {30'd3, 30'd2, 30'd1, 30'd0}, 4'h0, 16'hFFFF, 1'b1, 4'hB, 4'hF, 4'hB, 4'hF);
      tbl[5] = mk(4'hF, {30'd12, 30'd8, 30'd4, 30'd0}, 4'hA, 16'h1234, 1'b1, 4'hF, 4'h1, 4'h1, 4'h1);
      tbl[6] = mk(4'h0, {30'd1, 30'd2, 30'd3, 30'd0}, 4'hF, 16'hFFFF, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
      tbl[7] = mk(4'hA, {30'd1, 30'd1, 30'd1, 30'd1}, 4'h5, 16'h5A5A, 1'b1, 4'hF, 4'h2, 4'h2, 4'h2);
      tbl[8] = mk(4'hF, {30'd7, 30'd6, 30'd5, 30'd5}, 4'h3, 16'hC3C3, 1'b1, 4'h2, 4'hD, 4'h1, 4'hE);
      none = mk(4'h0, '0, 4'h0, 16'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

      rst_n = 1'b0;
      exp_stalls = '0;
      load(none);
      repeat (2) @(posedge clk);
      #1;
      run_cycle("reset", 1'b1, none);
      rst_n = 1'b1;

      for (int k = 0; k < 9; k++) begin
         load(tbl[k]);
         run_cycle($sformatf("tbl%0d", k), 1'b1, tbl[k]);
      end

      // Async reset mid-run: count to 5 from zero, then pull reset between edges.
      rst_n = 1'b0;
      #1;
      chk("pre_clear", d0_stalls, 44'd0);
      rst_n = 1'b1;
      exp_stalls = '0;
      load(tbl[1]);
      for (int k = 0; k < 5; k++) run_cycle($sformatf("conflict%0d", k), 1'b1, tbl[1]);
      chk("stalls_at_5", d0_stalls, 44'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("async_clear", d0_stalls, 44'd0);
      chk("async_clear1", d1_stalls, 44'd0);
      @(posedge clk);
      #1;
      chk("held_in_reset", d0_stalls, 44'd0);
      rst_n = 1'b1;
      exp_stalls = '0;
      run_cycle("resume", 1'b1, tbl[1]);
      chk("resume_count", d0_stalls, 44'd1);

      for (int k = 0; k < 300; k++) begin
         valid = 4'($urandom);
         rw    = 4'($urandom);
         tag   = 4'($urandom);
         rdy0  = 1'($urandom);
         rdy1  = 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            l_addr[i] = ($urandom_range(0, 1) == 1) ? 30'($urandom_range(0, 15)) : 30'($urandom);
            l_be[i]   = 4'($urandom);
            l_data[i] = $urandom;
         end
         run_cycle($sformatf("rnd%0d", k), 1'b0, none);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
